// File: rtl/mul.sv
// Sequential binary32 multiplier with a one-partial-product-per-clock shift-add
// mantissa multiply and round-to-nearest-even. Companion to div, with the same strobe protocol.
module mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic [31:0] output_z,
  output logic        output_z_stb
);

  // state         | meaning
  // get_in        | sample and unpack operands      special_cases | NaN/inf/zero, hidden bit
  // normalise_a/b | left-justify denormal operands  multiply_0/1/2 | setup, 24 shift-adds, split
  // normalise_1/2 | result normalise / denormalise  round, pack    | RNE, assemble binary32
  // put_z         | raise strobe, then drop it and return to get_in
  typedef enum logic [3:0] {
    S_GET_IN, S_SPECIAL_CASES, S_NORMALISE_A, S_NORMALISE_B,
    S_MULTIPLY_0, S_MULTIPLY_1, S_MULTIPLY_2, S_NORMALISE_1,
    S_NORMALISE_2, S_ROUND, S_PACK, S_PUT_Z
  } state_t;

  localparam logic signed [9:0] E_MAX  = 10'sd128;
  localparam logic signed [9:0] E_ZERO = -10'sd127;
  localparam logic signed [9:0] E_MIN  = -10'sd126;
  localparam logic signed [9:0] E_HI   = 10'sd127;
  localparam logic [31:0]       Q_NAN  = 32'hFFC0_0000;

  state_t             state_q, state_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic               guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
  logic [47:0]        product_q, product_d;
  logic [4:0]         count_q, count_d;
  logic [31:0]        z_q, z_d, output_z_q, output_z_d;
  logic               stb_q, stb_d;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (a_e_q == E_MAX) && (a_m_q != 24'd0);
  assign b_nan  = (b_e_q == E_MAX) && (b_m_q != 24'd0);
  assign a_inf  = (a_e_q == E_MAX) && (a_m_q == 24'd0);
  assign b_inf  = (b_e_q == E_MAX) && (b_m_q == 24'd0);
  assign a_zero = (a_e_q == E_ZERO) && (a_m_q == 24'd0);
  assign b_zero = (b_e_q == E_ZERO) && (b_m_q == 24'd0);

  assign output_z     = output_z_q;
  assign output_z_stb = stb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_GET_IN;
      a_m_q       <= '0;
      b_m_q       <= '0;
      z_m_q       <= '0;
      a_e_q       <= '0;
      b_e_q       <= '0;
      z_e_q       <= '0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      z_s_q       <= 1'b0;
      guard_q     <= 1'b0;
      round_bit_q <= 1'b0;
      sticky_q    <= 1'b0;
      product_q   <= '0;
      count_q     <= '0;
      z_q         <= '0;
      output_z_q  <= '0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_m_q       <= a_m_d;
      b_m_q       <= b_m_d;
      z_m_q       <= z_m_d;
      a_e_q       <= a_e_d;
      b_e_q       <= b_e_d;
      z_e_q       <= z_e_d;
      a_s_q       <= a_s_d;
      b_s_q       <= b_s_d;
      z_s_q       <= z_s_d;
      guard_q     <= guard_d;
      round_bit_q <= round_bit_d;
      sticky_q    <= sticky_d;
      product_q   <= product_d;
      count_q     <= count_d;
      z_q         <= z_d;
      output_z_q  <= output_z_d;
      stb_q       <= stb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_m_d       = a_m_q;
    b_m_d       = b_m_q;
    z_m_d       = z_m_q;
    a_e_d       = a_e_q;
    b_e_d       = b_e_q;
    z_e_d       = z_e_q;
    a_s_d       = a_s_q;
    b_s_d       = b_s_q;
    z_s_d       = z_s_q;
    guard_d     = guard_q;
    round_bit_d = round_bit_q;
    sticky_d    = sticky_q;
    product_d   = product_q;
    count_d     = count_q;
    z_d         = z_q;
    output_z_d  = output_z_q;
    stb_d       = stb_q;

    case (state_q)
      S_GET_IN: begin
        a_m_d   = {1'b0, input_a[22:0]};
        b_m_d   = {1'b0, input_b[22:0]};
        a_e_d   = $signed({2'b00, input_a[30:23]}) - E_HI;
        b_e_d   = $signed({2'b00, input_b[30:23]}) - E_HI;
        a_s_d   = input_a[31];
        b_s_d   = input_b[31];
        state_d = S_SPECIAL_CASES;
      end
      S_SPECIAL_CASES: begin
        state_d = S_PUT_Z;
        if (a_nan || b_nan) begin
          z_d = Q_NAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          z_d = Q_NAN;
        end else if (a_inf || b_inf) begin
          z_d = {a_s_q ^ b_s_q, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
          z_d = {a_s_q ^ b_s_q, 31'd0};
        end else begin
          // Denormals keep a zero hidden bit and take the minimum exponent.
          if (a_e_q == E_ZERO) a_e_d = E_MIN;
          else                 a_m_d[23] = 1'b1;
          if (b_e_q == E_ZERO) b_e_d = E_MIN;
          else                 b_m_d[23] = 1'b1;
          state_d = S_NORMALISE_A;
        end
      end
      S_NORMALISE_A: begin
        if (a_m_q[23]) begin
          state_d = S_NORMALISE_B;
        end else begin
          a_m_d = {a_m_q[22:0], 1'b0};
          a_e_d = a_e_q - 10'sd1;
        end
      end
      S_NORMALISE_B: begin
        if (b_m_q[23]) begin
          state_d = S_MULTIPLY_0;
        end else begin
          b_m_d = {b_m_q[22:0], 1'b0};
          b_e_d = b_e_q - 10'sd1;
        end
      end
      S_MULTIPLY_0: begin
        z_s_d     = a_s_q ^ b_s_q;
        z_e_d     = a_e_q + b_e_q + 10'sd1;
        product_d = '0;
        count_d   = '0;
        state_d   = S_MULTIPLY_1;
      end
      S_MULTIPLY_1: begin
        if (b_m_q[count_q]) product_d = product_q + ({24'd0, a_m_q} << count_q);
        if (count_q == 5'd23) state_d = S_MULTIPLY_2;
        else                  count_d = count_q + 5'd1;
      end
      S_MULTIPLY_2: begin
        z_m_d       = product_q[47:24];
        guard_d     = product_q[23];
        round_bit_d = product_q[22];
        sticky_d    = |product_q[21:0];
        state_d     = S_NORMALISE_1;
      end
      S_NORMALISE_1: begin
        if (!z_m_q[23] && (z_e_q > E_MIN)) begin
          z_e_d       = z_e_q - 10'sd1;
          z_m_d       = {z_m_q[22:0], guard_q};
          guard_d     = round_bit_q;
          round_bit_d = 1'b0;
        end else begin
          state_d = S_NORMALISE_2;
        end
      end
      S_NORMALISE_2: begin
        if (z_e_q < E_MIN) begin
          z_e_d       = z_e_q + 10'sd1;
          z_m_d       = {1'b0, z_m_q[23:1]};
          guard_d     = z_m_q[0];
          round_bit_d = guard_q;
          sticky_d    = sticky_q | round_bit_q;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        z_d[22:0]  = z_m_q[22:0];
        z_d[30:23] = z_e_q[7:0] + 8'd127;
        z_d[31]    = z_s_q;
        if ((z_e_q == E_MIN) && !z_m_q[23]) z_d[30:23] = 8'd0;
        if (z_e_q > E_HI) z_d = {z_s_q, 8'hFF, 23'd0};
        state_d = S_PUT_Z;
      end
      S_PUT_Z: begin
        if (!stb_q) begin
          output_z_d = z_q;
          stb_d      = 1'b1;
        end else begin
          stb_d   = 1'b0;
          state_d = S_GET_IN;
        end
      end
      default: state_d = S_GET_IN;
    endcase
  end

endmodule

// File: tb/tb_mul.sv
// Directed bench for mul: hand-computed products, strobe latency, hold behaviour
// and a reset landing in the middle of the shift-add loop.
module tb_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic [31:0] output_z;
  logic        output_z_stb;

  int checks   = 0;
  int failures = 0;

  mul dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_b      (input_b),
    .output_z     (output_z),
    .output_z_stb (output_z_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Entered just after an edge that leaves the DUT in get_in; the next edge samples.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_z, input int lat, input string tag);
    int n;
    n = 0;
    input_a = a;
    input_b = b;
    @(posedge clk);
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!output_z_stb && n < 200);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_z"}, output_z, exp_z);
    @(posedge clk);
    #1;
    chk({tag, "_stb_low"}, {31'd0, output_z_stb}, 32'd0);
    chk({tag, "_hold"}, output_z, exp_z);
  endtask

  initial begin
    rst     = 1'b1;
    input_a = '0;
    input_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stb", {31'd0, output_z_stb}, 32'd0);
    chk("reset_z", output_z, 32'd0);
    rst = 1'b0;

    run(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 35, "one_x_one");
    run(32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 35, "three_x_neg_two");
    run(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 35, "ulp_square");
    run(32'h7F80_0000, 32'h0000_0000, 32'hFFC0_0000, 2,  "inf_x_zero");
    run(32'h7FC0_0001, 32'h3F80_0000, 32'hFFC0_0000, 2,  "nan_x_one");
    run(32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, 2,  "inf_x_neg_one");
    run(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 2,  "negzero_x_two");
    run(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 35, "overflow");
    run(32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 34, "underflow");
    run(32'h0000_0001, 32'h4B00_0000, 32'h0080_0000, 58, "denormal_in");

    // Reset at the 11th edge after sampling, while the shift-add loop is running.
    input_a = 32'h4040_0000;
    input_b = 32'hC000_0000;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_stb", {31'd0, output_z_stb}, 32'd0);
    chk("midreset_z", output_z, 32'd0);
    rst = 1'b0;

    run(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 35, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
